// File: rtl/tlv_pkg.sv
// Shared definitions for the TLV record parser: parser states and the
// header geometry (one type byte followed by one length byte).
package tlv_pkg;

  typedef enum logic {
    HDR = 1'b0,
    PAY = 1'b1
  } tlv_state_t;

  localparam int HDR_BYTES = 2;
  localparam int LEN_W     = 8;

endpackage

// File: rtl/tlv_out_stage.sv
// One-entry output register for TLV beats. A load always wins over an accept,
// so a new beat can replace the one being accepted in the same cycle.
module tlv_out_stage #(
  parameter int DATA_OUT_BYTE_W   = 16,
  parameter int NUM_BYTES_TAKEN_W = 5
) (
  input  logic                         clk,
  input  logic                         sync_rst,
  input  logic                         load,
  input  logic                         accept,
  input  logic [DATA_OUT_BYTE_W*8-1:0] in_data,
  input  logic [NUM_BYTES_TAKEN_W-1:0] in_bytes,
  input  logic [7:0]                   in_type,
  input  logic                         in_sop,
  input  logic                         in_eop,
  output logic                         out_valid,
  output logic [DATA_OUT_BYTE_W*8-1:0] out_data,
  output logic [NUM_BYTES_TAKEN_W-1:0] out_bytes,
  output logic [7:0]                   out_type,
  output logic                         out_sop,
  output logic                         out_eop
);

  logic                         vld_p1;
  logic [DATA_OUT_BYTE_W*8-1:0] data_p1;
  logic [NUM_BYTES_TAKEN_W-1:0] bytes_p1;
  logic [7:0]                   type_p1;
  logic                         sop_p1;
  logic                         eop_p1;

  // Stage p1: registered beat presented downstream
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      bytes_p1 <= '0;
      type_p1  <= '0;
      sop_p1   <= 1'b0;
      eop_p1   <= 1'b0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      data_p1  <= in_data;
      bytes_p1 <= in_bytes;
      type_p1  <= in_type;
      sop_p1   <= in_sop;
      eop_p1   <= in_eop;
    end else if (accept) begin
      vld_p1   <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_bytes = bytes_p1;
  assign out_type  = type_p1;
  assign out_sop   = sop_p1;
  assign out_eop   = eop_p1;

endmodule

// File: rtl/tlv_parser.sv
// TLV record parser: pulls type/length headers and payload chunks from a byte
// FIFO window and emits payload beats of up to DATA_OUT_BYTE_W bytes.
module tlv_parser
  import tlv_pkg::*;
#(
  parameter int DATA_OUT_BYTE_W   = 16,
  parameter int ADD_W             = 6,
  parameter int NUM_BYTES_TAKEN_W = 5
) (
  input  logic                         clk,
  input  logic                         sync_rst,
  input  logic [DATA_OUT_BYTE_W*8-1:0] fifo_data,
  input  logic [ADD_W-1:0]             fifo_num_bytes,
  input  logic                         fifo_data_valid,
  output logic [NUM_BYTES_TAKEN_W-1:0] num_bytes_taken_from_fifo,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_OUT_BYTE_W*8-1:0] out_data,
  output logic [NUM_BYTES_TAKEN_W-1:0] out_bytes,
  output logic [7:0]                   out_type,
  output logic                         out_sop,
  output logic                         out_eop
);

  function automatic logic [DATA_OUT_BYTE_W*8-1:0] mask_bytes(
    input logic [DATA_OUT_BYTE_W*8-1:0] d,
    input logic [NUM_BYTES_TAKEN_W-1:0] n
  );
    logic [DATA_OUT_BYTE_W*8-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_OUT_BYTE_W; i++) begin
      if (i < int'(n)) r[i*8 +: 8] = d[i*8 +: 8];
    end
    return r;
  endfunction

  tlv_state_t                   state_p0;
  logic [LEN_W-1:0]             remaining_p0;
  logic                         first_p0;
  logic [7:0]                   type_p0;

  logic                         load_en;
  logic                         accept;
  logic [NUM_BYTES_TAKEN_W-1:0] chunk;
  logic [NUM_BYTES_TAKEN_W-1:0] take_req;
  logic                         take_done;
  logic                         beat_load;
  logic [7:0]                   hdr_type;
  logic [LEN_W-1:0]             hdr_len;
  logic [DATA_OUT_BYTE_W*8-1:0] beat_data;
  logic [NUM_BYTES_TAKEN_W-1:0] beat_bytes;
  logic [7:0]                   beat_type;
  logic                         beat_sop;
  logic                         beat_eop;

  assign hdr_type = fifo_data[7:0];
  assign hdr_len  = fifo_data[15:8];
  assign load_en  = !out_valid || out_ready;
  assign accept   = out_valid && out_ready;

  // The request depends only on registered state and out_ready; fifo_data_valid
  // merely qualifies whether the request completes this cycle.
  always_comb begin
    chunk = (int'(remaining_p0) < DATA_OUT_BYTE_W) ? NUM_BYTES_TAKEN_W'(remaining_p0)
                                                   : NUM_BYTES_TAKEN_W'(DATA_OUT_BYTE_W);
    take_req = (state_p0 == HDR) ? NUM_BYTES_TAKEN_W'(HDR_BYTES) : chunk;
    num_bytes_taken_from_fifo = (load_en && !sync_rst) ? take_req : '0;
    take_done = (num_bytes_taken_from_fifo != '0) && fifo_data_valid &&
                (int'(fifo_num_bytes) >= int'(take_req));
    beat_load = take_done && ((state_p0 == PAY) || (hdr_len == '0));
  end

  always_comb begin
    if (state_p0 == HDR) begin
      beat_data  = '0;
      beat_bytes = '0;
      beat_type  = hdr_type;
      beat_sop   = 1'b1;
      beat_eop   = 1'b1;
    end else begin
      beat_data  = mask_bytes(fifo_data, chunk);
      beat_bytes = chunk;
      beat_type  = type_p0;
      beat_sop   = first_p0;
      beat_eop   = (remaining_p0 == LEN_W'(chunk));
    end
  end

  // Stage p0: header/payload sequencing, advancing only on a completed take
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_p0     <= HDR;
      remaining_p0 <= '0;
      first_p0     <= 1'b0;
    end else if (take_done) begin
      case (state_p0)
        HDR: begin
          if (hdr_len != '0) begin
            state_p0     <= PAY;
            remaining_p0 <= hdr_len;
            first_p0     <= 1'b1;
          end
        end
        PAY: begin
          remaining_p0 <= remaining_p0 - LEN_W'(chunk);
          first_p0     <= 1'b0;
          if (remaining_p0 == LEN_W'(chunk)) state_p0 <= HDR;
        end
        default: state_p0 <= HDR;
      endcase
    end
  end

  // Record type is carried for the payload beats; no reset needed on data
  always_ff @(posedge clk) begin
    if (take_done && (state_p0 == HDR)) type_p0 <= hdr_type;
  end

  tlv_out_stage #(
    .DATA_OUT_BYTE_W  (DATA_OUT_BYTE_W),
    .NUM_BYTES_TAKEN_W(NUM_BYTES_TAKEN_W)
  ) u_out_stage (
    .clk      (clk),
    .sync_rst (sync_rst),
    .load     (beat_load),
    .accept   (accept),
    .in_data  (beat_data),
    .in_bytes (beat_bytes),
    .in_type  (beat_type),
    .in_sop   (beat_sop),
    .in_eop   (beat_eop),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_bytes(out_bytes),
    .out_type (out_type),
    .out_sop  (out_sop),
    .out_eop  (out_eop)
  );

endmodule

// File: tb/tb_tlv_parser.sv
// Bench for tlv_parser: a byte-queue FIFO feeds generated records; expected
// beats and take sizes are derived from the record list, not the RTL.
module tb_tlv_parser;

  localparam int W  = 16;
  localparam int AW = 6;
  localparam int NW = 5;

  logic            clk = 1'b0;
  logic            sync_rst;
  logic [W*8-1:0]  fifo_data;
  logic [AW-1:0]   fifo_num_bytes;
  logic            fifo_data_valid;
  logic [NW-1:0]   num_bytes_taken_from_fifo;
  logic            out_valid;
  logic            out_ready;
  logic [W*8-1:0]  out_data;
  logic [NW-1:0]   out_bytes;
  logic [7:0]      out_type;
  logic            out_sop;
  logic            out_eop;

  always #5 clk = ~clk;

  tlv_parser #(
    .DATA_OUT_BYTE_W  (W),
    .ADD_W            (AW),
    .NUM_BYTES_TAKEN_W(NW)
  ) dut (
    .clk                      (clk),
    .sync_rst                 (sync_rst),
    .fifo_data                (fifo_data),
    .fifo_num_bytes           (fifo_num_bytes),
    .fifo_data_valid          (fifo_data_valid),
    .num_bytes_taken_from_fifo(num_bytes_taken_from_fifo),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .out_data                 (out_data),
    .out_bytes                (out_bytes),
    .out_type                 (out_type),
    .out_sop                  (out_sop),
    .out_eop                  (out_eop)
  );

  typedef struct {
    logic [7:0]     typ;
    int             nb;
    logic [W*8-1:0] data;
    bit             sop;
    bit             eop;
  } beat_t;

  logic [7:0] src_q[$];
  logic [7:0] fifo_q[$];
  beat_t      exp_beats[$];
  int         exp_take[$];

  int checks = 0;
  int errors = 0;
  bit stall = 1'b0;
  int fifo_cnt = 0;

  // Observed values of the most recent step, and of the one before it
  int             o_take;
  logic           o_valid, o_sop, o_eop;
  logic [W*8-1:0] o_data;
  logic [NW-1:0]  o_bytes;
  logic [7:0]     o_type;
  logic           p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1;
  logic [159:0]   p_fields;

  // FIFO answers a request only when it holds enough bytes and is not stalled
  always_comb begin
    fifo_data_valid = (num_bytes_taken_from_fifo != '0) &&
                      (fifo_cnt >= int'(num_bytes_taken_from_fifo)) && !stall;
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_cnt       = fifo_q.size();
    fifo_num_bytes = AW'(fifo_cnt);
    fifo_data      = '0;
    for (int i = 0; i < W; i++)
      if (i < fifo_cnt) fifo_data[i*8 +: 8] = fifo_q[i];
  endtask

  task automatic add_record(input logic [7:0] t, input int len, input bit seq);
    logic [7:0] pl[$];
    logic [7:0] b;
    logic [7:0] lb;
    beat_t      bt;
    int         off;
    int         c;
    lb = len[7:0];
    src_q.push_back(t);
    src_q.push_back(lb);
    exp_take.push_back(2);
    for (int i = 0; i < len; i++) begin
      b = seq ? 8'(i + 1) : 8'($urandom);
      pl.push_back(b);
      src_q.push_back(b);
    end
    if (len == 0) begin
      bt.typ = t; bt.nb = 0; bt.data = '0; bt.sop = 1'b1; bt.eop = 1'b1;
      exp_beats.push_back(bt);
    end else begin
      off = 0;
      while (off < len) begin
        c = (len - off < W) ? (len - off) : W;
        exp_take.push_back(c);
        bt.typ = t; bt.nb = c; bt.data = '0;
        for (int i = 0; i < c; i++) bt.data[i*8 +: 8] = pl[off + i];
        bt.sop = (off == 0);
        bt.eop = (off + c == len);
        exp_beats.push_back(bt);
        off += c;
      end
    end
  endtask

  task automatic compare(input bit rst_in, output bit done);
    logic [159:0] fields;
    beat_t        e;
    int           want;
    o_take  = int'(num_bytes_taken_from_fifo);
    o_valid = out_valid; o_data = out_data; o_bytes = out_bytes;
    o_type  = out_type;  o_sop  = out_sop;  o_eop   = out_eop;
    fields  = {out_valid, out_type, out_bytes, out_data, out_sop, out_eop};
    done    = 1'b0;
    if (p_valid && !p_ready && !p_rst) check("hold", fields, p_fields);
    if (rst_in) begin
      check("take_in_rst", 160'(o_take), 160'(0));
    end else begin
      if (out_valid && !out_ready) begin
        check("take_blocked", 160'(o_take), 160'(0));
      end else begin
        want = (exp_take.size() > 0) ? exp_take[0] : 2;
        check("take_req", 160'(o_take), 160'(want));
      end
      done = (o_take != 0) && fifo_data_valid;
      if (done && exp_take.size() > 0) void'(exp_take.pop_front());
      if (out_valid && out_ready) begin
        if (exp_beats.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got type %0h bytes %0d expected none", out_type, out_bytes);
        end else begin
          e = exp_beats.pop_front();
          check("beat", {out_type, out_bytes, out_data, out_sop, out_eop},
                {e.typ, 5'(e.nb), e.data, e.sop, e.eop});
        end
      end
    end
    p_valid = out_valid; p_ready = out_ready; p_rst = rst_in; p_fields = fields;
  endtask

  task automatic step(input bit rdy, input bit stl, input int push_n, input bit rst_in);
    bit done;
    int n;
    @(negedge clk);
    out_ready = rdy;
    stall     = stl;
    sync_rst  = rst_in;
    for (int i = 0; i < push_n; i++)
      if (src_q.size() > 0 && fifo_q.size() < 63) fifo_q.push_back(src_q.pop_front());
    refresh();
    #1;
    n = o_take;
    compare(rst_in, done);
    n = o_take;
    @(posedge clk);
    #1;
    if (rst_in) begin
      fifo_q.delete(); src_q.delete(); exp_beats.delete(); exp_take.delete();
    end else if (done) begin
      for (int i = 0; i < n; i++) void'(fifo_q.pop_front());
    end
    refresh();
  endtask

  initial begin
    int budget;
    int ln;
    int r;
    sync_rst  = 1'b1;
    out_ready = 1'b1;
    refresh();
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);

    // Reset state
    step(1, 0, 0, 0);
    check("rst_state", {o_valid, o_data, o_bytes, o_type, o_sop, o_eop}, '0);

    // A5 03 01 02 03
    add_record(8'hA5, 3, 1'b1);
    step(1, 0, 99, 0);
    check("a5_take2", 160'(o_take), 160'(2));
    step(1, 0, 99, 0);
    check("a5_take3", 160'(o_take), 160'(3));
    step(1, 0, 99, 0);
    check("a5_beat", {o_valid, o_type, o_bytes, o_data[23:0], o_sop, o_eop},
          {1'b1, 8'hA5, 5'd3, 24'h030201, 1'b1, 1'b1});

    // Type 0x10, L=40: 16/16/8 on consecutive cycles
    add_record(8'h10, 40, 1'b1);
    step(1, 0, 99, 0);
    step(1, 0, 99, 0);
    step(1, 0, 99, 0);
    check("l40_b1", {o_valid, o_bytes, o_sop, o_eop}, {1'b1, 5'd16, 1'b1, 1'b0});
    step(1, 0, 99, 0);
    check("l40_b2", {o_valid, o_bytes, o_sop, o_eop}, {1'b1, 5'd16, 1'b0, 1'b0});
    step(1, 0, 99, 0);
    check("l40_b3", {o_valid, o_bytes, o_sop, o_eop, o_data[7:0]}, {1'b1, 5'd8, 1'b0, 1'b1, 8'd33});

    // Zero-length record followed by a one-byte record
    add_record(8'h07, 0, 1'b1);
    add_record(8'h22, 1, 1'b1);
    step(1, 0, 99, 0);
    step(1, 0, 99, 0);
    check("zl_beat", {o_valid, o_type, o_bytes, o_data, o_sop, o_eop, 5'(o_take)},
          {1'b1, 8'h07, 5'd0, 128'd0, 1'b1, 1'b1, 5'd2});
    step(1, 0, 99, 0);
    step(1, 0, 99, 0);
    check("zl_next", {o_valid, o_type, o_bytes}, {1'b1, 8'h22, 5'd1});
    step(1, 0, 99, 0);

    // Backpressure for 5 cycles with a beat pending
    add_record(8'h33, 40, 1'b0);
    step(1, 0, 99, 0);
    step(1, 0, 99, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 99, 0);
      check("bp_take0", {o_valid, 5'(o_take)}, {1'b1, 5'd0});
    end
    step(1, 0, 99, 0);
    check("bp_resume", {o_valid, 5'(o_take), o_sop}, {1'b1, 5'd16, 1'b1});
    for (int i = 0; i < 3; i++) step(1, 0, 99, 0);

    // L=20 with only 10 payload bytes available
    add_record(8'h44, 20, 1'b0);
    step(1, 0, 12, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      check("short_wait", {o_valid, 5'(o_take)}, {1'b0, 5'd16});
    end
    step(1, 0, 99, 0);
    step(1, 0, 99, 0);
    check("short_b1", {o_valid, o_bytes}, {1'b1, 5'd16});
    step(1, 0, 99, 0);
    check("short_b2", {o_valid, o_bytes, o_eop}, {1'b1, 5'd4, 1'b1});
    step(1, 0, 99, 0);

    // Reset during the second beat of an L=40 record
    add_record(8'h55, 40, 1'b0);
    step(1, 0, 99, 0);
    step(1, 0, 99, 0);
    step(1, 0, 99, 0);
    step(1, 0, 0, 1);
    check("mid_rst_beat2", {o_valid, o_sop}, {1'b1, 1'b0});
    step(1, 0, 0, 0);
    check("post_rst", {o_valid, 5'(o_take)}, {1'b0, 5'd2});
    add_record(8'h77, 2, 1'b1);
    step(1, 0, 99, 0);
    step(1, 0, 99, 0);
    step(1, 0, 99, 0);
    check("post_rst_rec", {o_valid, o_type, o_bytes, o_data[15:0], o_sop, o_eop},
          {1'b1, 8'h77, 5'd2, 16'h0201, 1'b1, 1'b1});

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (src_q.size() < 40) begin
        r = $urandom % 10;
        ln = (r == 0) ? 0 : (r == 1) ? 255 : (r == 2) ? 40 : int'($urandom_range(1, 50));
        add_record(8'($urandom), ln, 1'b0);
      end
      step(($urandom % 10) < 7, ($urandom % 8) == 0, int'($urandom_range(0, 10)), 1'b0);
    end

    budget = 2000;
    while ((exp_beats.size() > 0 || src_q.size() > 0 || fifo_q.size() > 0) && budget > 0) begin
      step(1, 0, 16, 0);
      budget--;
    end
    check("drain", 160'(exp_beats.size()), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
